load_req_unit: RTL

LOAD_REQ_UNIT -- requirements
Module: load_req_unit

---
 rtl/load_req_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/load_req_unit.sv
// ---------------------------------------------------------------------------
// load_req_unit
//
// Issues one doubleword read to data memory for each core load and returns
// the raw doubleword, together with the captured byte offset and funct3, to
// the load alignment mux. If memory does not respond within TIMEOUT_CYCLES
// WAIT cycles, the load completes with an access fault and zero data.
//
// Handshake semantics (one rule for every valid/ready pair in this block):
//   A transfer happens on a rising edge where valid and ready are both high.
//   Once valid is raised, it stays high and its payload stays stable until
//   that transfer. The response channel has no ready signal. This block
//   always accepts a response, but only in WAIT. A response at any other
//   time is dropped.
//
// Parameters
//   DATA_WIDTH      memory read data / o_data width
//   ADDR_WIDTH      effective address width (must be > 3)
//   TIMEOUT_CYCLES  WAIT cycles without a response before the fault abort
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_rst             synchronous active-high reset, overrides every input
//   i_load_start      one-cycle load request, accepted only in IDLE
//   i_func_3          load funct3, captured with the request (not decoded)
//   i_addr            effective load address, captured with the request
//   o_busy            high in every state except IDLE
//   o_mem_req_valid   read request valid (REQ state)
//   i_mem_req_ready   memory accepts the read request
//   o_mem_addr        doubleword-aligned read address
//   i_mem_resp_valid  read response valid
//   i_mem_resp_data   read response data
//   i_mem_resp_err    bus error, qualified by i_mem_resp_valid
//   o_data_valid      one-cycle completion pulse (DONE state)
//   o_data            registered raw doubleword
//   o_addr_offset     captured i_addr[2:0]
//   o_func_3          captured funct3
//   o_access_fault    load access fault, valid with o_data_valid
//   o_state           FSM state for debug and checkers
//                     (0 = IDLE, 1 = REQ, 2 = WAIT, 3 = DONE)
// ---------------------------------------------------------------------------
module load_req_unit #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_start,
  input  logic [2:0]            i_func_3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_busy,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
  input  logic                  i_mem_resp_err,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [2:0]            o_addr_offset,
  output logic [2:0]            o_func_3,
  output logic                  o_access_fault,
  output logic [1:0]            o_state
);

  // The counter is wide enough to hold TIMEOUT_CYCLES-1, its terminal value.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            func3_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  fault_q;
  logic [CNT_W-1:0]      cnt_q;

  // Event strobes decoded from the current state and the inputs.
  logic accept_start;
  logic req_handshake;
  logic resp_take;
  logic timeout_hit;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    accept_start    = 1'b0;
    req_handshake   = 1'b0;
    resp_take       = 1'b0;
    timeout_hit     = 1'b0;
    o_busy          = 1'b1;
    o_mem_req_valid = 1'b0;
    o_data_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_load_start) begin
          accept_start = 1'b1;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          req_handshake = 1'b1;
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        // A response on the terminal counter cycle beats the timeout.
        if (i_mem_resp_valid) begin
          resp_take = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        // A start in this cycle is dropped. The core re-issues it after
        // o_busy falls.
        o_data_valid = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Request capture. Address and funct3 stay stable from the accepted start
  // to the next one. This keeps o_mem_addr constant while the request is
  // pending, and it keeps the offset and funct3 valid after DONE.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      func3_q <= '0;
    end else if (accept_start) begin
      addr_q  <= i_addr;
      func3_q <= i_func_3;
    end
  end

  // -------------------------------------------------------------------------
  // Timeout counter. It clears on the request handshake and counts the WAIT
  // cycles that pass without a response.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (req_handshake) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT && !resp_take && !timeout_hit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Result registers. o_data is written only when the load completes, so it
  // keeps the previous result until the next completion. The fault flag is
  // cleared on acceptance so that a stale fault never appears with a clean
  // completion.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= '0;
      fault_q <= 1'b0;
    end else if (accept_start) begin
      fault_q <= 1'b0;
    end else if (resp_take) begin
      data_q  <= i_mem_resp_data;
      fault_q <= i_mem_resp_err;
    end else if (timeout_hit) begin
      data_q  <= '0;
      fault_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output wiring
  // -------------------------------------------------------------------------
  assign o_mem_addr     = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign o_addr_offset  = addr_q[2:0];
  assign o_func_3       = func3_q;
  assign o_data         = data_q;
  assign o_access_fault = fault_q;
  assign o_state        = state_q;

endmodule
